// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, the timer register map and the slave response-FSM states.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_LOAD     = 5'h04;
  localparam logic [4:0] OFS_VALUE    = 5'h08;
  localparam logic [4:0] OFS_STATUS   = 5'h0C;
  localparam logic [4:0] OFS_PRESCALE = 5'h10;
  // First offset past the register file; anything at or above it is an ERROR response.
  localparam logic [4:0] OFS_LIMIT    = 5'h14;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_ERR1 = 2'd1,
    RSP_ERR2 = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/ahblite_timer_if.sv
// AHB-Lite slave-port bundle; HREADY is the interconnect's merged ready fed back to the slave.
interface ahblite_timer_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahblite_timer_core.sv
// Timer datapath: prescaler, 32-bit down-counter with reload/one-shot, and the sticky FLAG.
module ahblite_timer_core
  import ahblite_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  oneshot,
  input  logic [31:0]           load,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  en_start,
  input  logic                  value_wr,
  input  logic                  flag_clr,
  output logic [31:0]           value,
  output logic                  flag,
  output logic                  en_clr
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic                  expire;

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (value == '0);
  assign en_clr = expire && oneshot;

  // Software VALUE writes outrank a same-cycle tick; a hardware FLAG set outranks W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      value <= '0;
      flag  <= 1'b0;
    end else begin
      if (value_wr || en_start) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
      end

      if (value_wr) begin
        value <= load;
      end else if (tick) begin
        if (value != '0) begin
          value <= value - 1'b1;
        end else if (!oneshot) begin
          value <= load;
        end
      end

      if (expire) begin
        flag <= 1'b1;
      end else if (flag_clr) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahblite_timer.sv
// AHB-Lite timer slave: address/data-phase pipeline, ERROR response FSM, register file and read mux.
module ahblite_timer
  import ahblite_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int PRESCALE_W = 16
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahblite_timer_if.slave bus,
  output logic           IRQ
);

  localparam logic [ADDR_W-3:0] W_CTRL     = (ADDR_W-2)'(OFS_CTRL >> 2);
  localparam logic [ADDR_W-3:0] W_LOAD     = (ADDR_W-2)'(OFS_LOAD >> 2);
  localparam logic [ADDR_W-3:0] W_VALUE    = (ADDR_W-2)'(OFS_VALUE >> 2);
  localparam logic [ADDR_W-3:0] W_STATUS   = (ADDR_W-2)'(OFS_STATUS >> 2);
  localparam logic [ADDR_W-3:0] W_PRESCALE = (ADDR_W-2)'(OFS_PRESCALE >> 2);

  rsp_state_e            state;
  logic                  hreadyout_r;
  logic                  hresp_r;

  logic                  acc_p0;
  logic                  err_p0;
  logic [ADDR_W-1:0]     ofs_p0;

  logic                  vld_p1;
  logic                  err_p1;
  logic                  write_p1;
  logic [ADDR_W-3:0]     addr_p1;

  logic                  wr_p1;
  logic                  rd_p1;
  logic                  wr_ctrl;
  logic                  wr_load;
  logic                  wr_value;
  logic                  wr_status;
  logic                  wr_prescale;

  logic                  ctrl_en;
  logic                  ctrl_ie;
  logic                  ctrl_oneshot;
  logic [31:0]           load_r;
  logic [PRESCALE_W-1:0] prescale_r;

  logic [31:0]           value;
  logic                  flag;
  logic                  en_clr;
  logic                  en_start;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign unused_bits = ^{bus.HADDR[31:ADDR_W], bus.HTRANS[0]};

  assign ofs_p0 = bus.HADDR[ADDR_W-1:0];
  assign acc_p0 = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign err_p0 = (ofs_p0 >= ADDR_W'(OFS_LIMIT)) |
                  (bus.HWRITE & (bus.HSIZE != HSIZE_WORD));

  // ---- address phase -> data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      write_p1 <= 1'b0;
    end else begin
      vld_p1   <= acc_p0;
      err_p1   <= err_p0;
      write_p1 <= bus.HWRITE;
    end
  end

  always_ff @(posedge HCLK) begin
    addr_p1 <= bus.HADDR[ADDR_W-1:2];
  end

  // A wait state is inserted only for ERROR, so ERR1 is the one cycle the bus HREADY is low.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= RSP_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      case (state)
        RSP_ERR1: begin
          state       <= RSP_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        RSP_IDLE, RSP_ERR2: begin
          if (acc_p0 && err_p0) begin
            state       <= RSP_ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= 1'b1;
          end else begin
            state       <= RSP_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        default: begin
          state       <= RSP_IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_p1       = vld_p1 & ~err_p1 & write_p1;
  assign rd_p1       = vld_p1 & ~err_p1 & ~write_p1;
  assign wr_ctrl     = wr_p1 & (addr_p1 == W_CTRL);
  assign wr_load     = wr_p1 & (addr_p1 == W_LOAD);
  assign wr_value    = wr_p1 & (addr_p1 == W_VALUE);
  assign wr_status   = wr_p1 & (addr_p1 == W_STATUS);
  assign wr_prescale = wr_p1 & (addr_p1 == W_PRESCALE);
  assign en_start    = wr_ctrl & bus.HWDATA[CTRL_EN] & ~ctrl_en;

  // ---- data phase: register writes commit on the edge that ends it
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_r       <= '0;
      prescale_r   <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= bus.HWDATA[CTRL_EN];
        ctrl_ie      <= bus.HWDATA[CTRL_IE];
        ctrl_oneshot <= bus.HWDATA[CTRL_ONESHOT];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (wr_load) begin
        load_r <= bus.HWDATA;
      end
      if (wr_prescale) begin
        prescale_r <= bus.HWDATA[PRESCALE_W-1:0];
      end
    end
  end

  ahblite_timer_core #(
    .PRESCALE_W (PRESCALE_W)
  ) u_core (
    .clk      (HCLK),
    .rst      (HRESET),
    .en       (ctrl_en),
    .oneshot  (ctrl_oneshot),
    .load     (load_r),
    .prescale (prescale_r),
    .en_start (en_start),
    .value_wr (wr_value),
    .flag_clr (wr_status & bus.HWDATA[0]),
    .value    (value),
    .flag     (flag),
    .en_clr   (en_clr)
  );

  always_comb begin
    rdata = '0;
    if (rd_p1) begin
      case (addr_p1)
        W_CTRL:     rdata = {29'b0, ctrl_oneshot, ctrl_ie, ctrl_en};
        W_LOAD:     rdata = load_r;
        W_VALUE:    rdata = value;
        W_STATUS:   rdata = {31'b0, flag};
        W_PRESCALE: rdata = 32'(prescale_r);
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;
  assign IRQ           = flag & ctrl_ie;

endmodule

// File: tb/tb_ahblite_timer.sv
// Directed bench for ahblite_timer: bus protocol, periodic/one-shot timing, W1C races, ERROR responses.
module tb_ahblite_timer;
  import ahblite_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  logic IRQ;
  int   n_total = 0;
  int   n_pass  = 0;

  // VALUE seen in the data-phase cycles d1..d16 after the CTRL=EN|IE write (LOAD=3, PRESCALE=1).
  logic [31:0] exp_v [16] = '{32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3,
                              32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd3};
  logic [31:0] exp_os [4] = '{32'd1, 32'd0, 32'd0, 32'd0};

  ahblite_timer_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahblite_timer #(
    .ADDR_W     (5),
    .PRESCALE_W (16)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus),
    .IRQ    (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = HSIZE_WORD;
    bus.HADDR  = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] size);
    bus.HSEL   = 1'b1;
    bus.HTRANS = HTRANS_NONSEQ;
    bus.HADDR  = 32'h4000_0000 | a;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  // Returns in the first cycle after the commit edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1, HSIZE_WORD);
    step();
    idle_bus();
    bus.HWDATA = d;
    step();
  endtask

  // Returns in the data-phase cycle, bus already idle.
  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_phase(a, 1'b0, HSIZE_WORD);
    step();
    idle_bus();
    check({tag, "_rsp"}, {30'b0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    check(tag, bus.HRDATA, exp);
  endtask

  task automatic rsp_check(input string tag, input logic [1:0] exp);
    check(tag, {30'b0, bus.HREADYOUT, bus.HRESP}, {30'b0, exp});
  endtask

  initial begin
    HRESET     = 1'b1;
    bus.HWDATA = 32'h0;
    idle_bus();
    repeat (2) step();
    rsp_check("rst_rsp", 2'b10);
    check("rst_rdata", bus.HRDATA, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);
    HRESET = 1'b0;

    rd_check("rst_ctrl", OFS_CTRL, 32'h0);
    rd_check("rst_load", OFS_LOAD, 32'h0);
    rd_check("rst_value", OFS_VALUE, 32'h0);
    rd_check("rst_status", OFS_STATUS, 32'h0);
    rd_check("rst_prescale", OFS_PRESCALE, 32'h0);
    check("rst_irq2", {31'b0, IRQ}, 32'h0);

    // Write immediately followed by a read of the same register.
    addr_phase(OFS_LOAD, 1'b1, HSIZE_WORD);
    step();
    bus.HWDATA = 32'hA5A5_0001;
    addr_phase(OFS_LOAD, 1'b0, HSIZE_WORD);
    step();
    idle_bus();
    check("b2b_load", bus.HRDATA, 32'hA5A5_0001);
    bus_write(OFS_PRESCALE, 32'h0001_2345);
    rd_check("prescale_trunc", OFS_PRESCALE, 32'h0000_2345);
    bus_write(OFS_CTRL, 32'hFFFF_FFF0);
    rd_check("ctrl_rsvd", OFS_CTRL, 32'h0);

    // Periodic mode, LOAD=3, PRESCALE=1: period 8 cycles.
    bus_write(OFS_LOAD, 32'd3);
    bus_write(OFS_PRESCALE, 32'd1);
    bus_write(OFS_VALUE, 32'hDEAD_BEEF);
    rd_check("value_wr_load", OFS_VALUE, 32'd3);
    bus_write(OFS_CTRL, 32'h3);
    for (int k = 0; k < 16; k++) begin
      addr_phase(OFS_VALUE, 1'b0, HSIZE_WORD);
      step();
      check($sformatf("per_value_d%0d", k + 1), bus.HRDATA, exp_v[k]);
      check($sformatf("per_irq_d%0d", k + 1), {31'b0, IRQ}, (k + 1 >= 8) ? 32'h1 : 32'h0);
    end
    idle_bus();
    // Now in d16; reloads set FLAG at the edges ending d23, d31.
    bus_write(OFS_STATUS, 32'h1);
    rd_check("w1c_status", OFS_STATUS, 32'h0);
    check("w1c_irq", {31'b0, IRQ}, 32'h0);
    repeat (3) step();
    bus_write(OFS_STATUS, 32'h1);
    rd_check("race_status", OFS_STATUS, 32'h1);
    check("race_irq", {31'b0, IRQ}, 32'h1);
    bus_write(OFS_STATUS, 32'h1);
    rd_check("clr_status", OFS_STATUS, 32'h0);
    check("clr_irq", {31'b0, IRQ}, 32'h0);
    bus_write(OFS_CTRL, 32'h0);
    rd_check("dis_value", OFS_VALUE, 32'd0);
    repeat (6) step();
    rd_check("dis_status", OFS_STATUS, 32'h0);

    // One-shot, LOAD=2, PRESCALE=0.
    bus_write(OFS_LOAD, 32'd2);
    bus_write(OFS_PRESCALE, 32'd0);
    bus_write(OFS_VALUE, 32'h0);
    bus_write(OFS_CTRL, 32'h7);
    for (int k = 0; k < 4; k++) begin
      addr_phase(OFS_VALUE, 1'b0, HSIZE_WORD);
      step();
      check($sformatf("os_value_d%0d", k + 1), bus.HRDATA, exp_os[k]);
    end
    idle_bus();
    repeat (3) step();
    rd_check("os_ctrl", OFS_CTRL, 32'h6);
    rd_check("os_value", OFS_VALUE, 32'h0);
    rd_check("os_status", OFS_STATUS, 32'h1);
    check("os_irq", {31'b0, IRQ}, 32'h1);

    // Illegal read; a write offered during ERR1 must be ignored; ERR2 chains into ERR1.
    addr_phase(32'h18, 1'b0, HSIZE_WORD);
    step();
    rsp_check("err18_c1", 2'b01);
    check("err18_rdata", bus.HRDATA, 32'h0);
    addr_phase(OFS_LOAD, 1'b1, HSIZE_WORD);
    step();
    rsp_check("err18_c2", 2'b11);
    bus.HWDATA = 32'hDEAD_BEEF;
    addr_phase(32'h1C, 1'b0, HSIZE_WORD);
    step();
    rsp_check("err1c_c1", 2'b01);
    idle_bus();
    step();
    rsp_check("err1c_c2", 2'b11);
    step();
    rsp_check("err_back_idle", 2'b10);
    rd_check("err_load_kept", OFS_LOAD, 32'd2);

    // Byte write is illegal; byte read is legal; offset 0x14 is the first illegal offset.
    addr_phase(OFS_LOAD, 1'b1, 3'b000);
    step();
    rsp_check("bytew_c1", 2'b01);
    idle_bus();
    bus.HWDATA = 32'h55;
    step();
    rsp_check("bytew_c2", 2'b11);
    rd_check("bytew_load_kept", OFS_LOAD, 32'd2);
    addr_phase(OFS_LOAD, 1'b0, 3'b000);
    step();
    idle_bus();
    rsp_check("byter_rsp", 2'b10);
    check("byter_data", bus.HRDATA, 32'd2);
    addr_phase(32'h14, 1'b0, HSIZE_WORD);
    step();
    rsp_check("err14_c1", 2'b01);
    idle_bus();
    step();
    rsp_check("err14_c2", 2'b11);

    // Reset landing in ERR1.
    bus_write(OFS_PRESCALE, 32'd5);
    addr_phase(32'h1C, 1'b0, HSIZE_WORD);
    step();
    rsp_check("rstE_c1", 2'b01);
    idle_bus();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    rsp_check("rstE_rsp", 2'b10);
    check("rstE_irq", {31'b0, IRQ}, 32'h0);
    rd_check("rstE_ctrl", OFS_CTRL, 32'h0);
    rd_check("rstE_load", OFS_LOAD, 32'h0);
    rd_check("rstE_value", OFS_VALUE, 32'h0);
    rd_check("rstE_status", OFS_STATUS, 32'h0);
    rd_check("rstE_prescale", OFS_PRESCALE, 32'h0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahblite_timer.md
Name: ahblite_timer

Overview:
- AHB-Lite slave responder: the completer side of the bus whose HSEL lines the address decoder drives.
- Sits on peripheral port P2 (window 0x4000_0000–0x4000_FFFF).
- Provides a prescaled 32-bit down-counter with a one-shot or periodic mode and a level interrupt to the Cortex-M0.
- Zero-wait-state for legal accesses; two-cycle ERROR response for illegal ones.

Parameters:
- ADDR_W, 5, number of low HADDR bits decoded; register offsets 0x00–0x1F.
- PRESCALE_W, 16, width of the PRESCALE register.

Ports:
- HCLK, input, 1, clock.
- HRESET, input, 1, synchronous active-high reset.
- HSEL, input, 1, slave select from the decoder.
- HADDR, input, 32, address; only [ADDR_W-1:2] decoded.
- HTRANS, input, 2, transfer type; bit1 = NONSEQ/SEQ.
- HWRITE, input, 1, 1 = write.
- HSIZE, input, 3, transfer size.
- HWDATA, input, 32, write data, valid in the data phase.
- HREADY, input, 1, bus-wide ready; qualifies the address phase.
- HREADYOUT, output, 1, slave ready.
- HRESP, output, 1, 0 = OKAY, 1 = ERROR.
- HRDATA, output, 32, read data.
- IRQ, output, 1, level interrupt.

Behaviour:
- Reset (HRESET=1 at a HCLK edge):
  - CTRL, LOAD, VALUE, STATUS, PRESCALE and the prescaler count clear to 0.
  - HREADYOUT=1, HRESP=0, HRDATA=0, IRQ=0.
  - Any pending data phase is abandoned.
- Address phase accepted when HSEL & HTRANS[1] & HREADY.
  - Register the offset, HWRITE and an error flag.
  - Error if offset ≥ 0x14, or if a write has HSIZE≠3'b010.
  - Reads of any size are legal.
- Register map:
  - 0x00 CTRL, RW: bit0 EN, bit1 IE, bit2 ONESHOT; other bits read as 0.
  - 0x04 LOAD, RW, 32 bits.
  - 0x08 VALUE: reads the current count. Any write sets VALUE←LOAD and clears the prescaler count; HWDATA is ignored.
  - 0x0C STATUS: bit0 FLAG; writing 1 clears it.
  - 0x10 PRESCALE, RW, PRESCALE_W bits, zero-extended on read.
- Legal data phase:
  - HREADYOUT=1, HRESP=0.
  - A write takes HWDATA on the HCLK edge that ends the data phase.
  - For a read, HRDATA shows the register value during the data phase; it is 0 for writes and idle cycles.
  - Back-to-back write then read of the same register returns the new value.
- Error data phase:
  - Cycle 1: HREADYOUT=0, HRESP=1.
  - Cycle 2: HREADYOUT=1, HRESP=1.
  - No register changes; HRDATA=0.
  - An address phase arriving during cycle 1 is ignored, because HREADY is low.
- Response FSM: IDLE → ERR1 → ERR2 → IDLE, or IDLE → ERR1 again if another illegal address phase is accepted in ERR2.
- Prescaler:
  - Counts 0..PRESCALE while EN=1. A tick occurs in the cycle the count equals PRESCALE; the count then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
- On a tick with EN=1:
  - VALUE≠0: VALUE decrements by 1.
  - VALUE=0, periodic: VALUE←LOAD and FLAG←1.
  - VALUE=0, ONESHOT: FLAG←1, EN←0, VALUE stays 0.
  - Periodic period = (LOAD+1)·(PRESCALE+1) cycles.
- EN written 0→1: prescaler count clears to 0. VALUE is unchanged.
- EN=0: prescaler and VALUE hold.
- LOAD writes affect VALUE only at the next reload or VALUE write.
- Simultaneous events:
  - Hardware FLAG set in the same cycle as a software W1C: set wins, FLAG=1.
  - Hardware EN clear (one-shot) in the same cycle as a CTRL write: the CTRL write wins.
  - Tick in the same cycle as a VALUE write: the VALUE write wins (VALUE=LOAD).
- IRQ = FLAG & IE, driven from registered state with no combinational path from bus inputs.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HSIZE_WORD.
  - Timer register offsets and CTRL bit indices.
  - Response-FSM state enum.
- Sub-module ahblite_timer_core: prescaler, VALUE counter and FLAG.
  - Inputs: register write strobes and data.
  - Outputs: VALUE, FLAG, the EN-clear pulse.
- The top level keeps the AHB data-phase register, the response FSM and the read mux.

Test Plan:
- Reset, then read all five registers → HRDATA=0 each, HRESP=0, HREADYOUT=1 throughout, IRQ=0.
- Write LOAD=3, PRESCALE=1, CTRL=0x3 (EN|IE) → VALUE reads 3,2,1,0 at 2-cycle spacing; FLAG=1 and IRQ=1 on the cycle VALUE reloads to 3; period 8 cycles.
- ONESHOT: CTRL=0x7, LOAD=2, PRESCALE=0 → after 3 ticks FLAG=1, CTRL reads 0x6, VALUE holds 0.
- Write STATUS=1 in the cycle a reload sets FLAG → FLAG remains 1. Then write STATUS=1 with no tick → FLAG=0, IRQ=0.
- Read offset 0x18, then byte write (HSIZE=0) to 0x04 → each gives {HREADYOUT,HRESP}= {0,1},{1,1}; LOAD unchanged.
- Assert HRESET during the ERR1 cycle → next cycle HREADYOUT=1, HRESP=0, all registers 0.
